lcd_ctrl_gen: RTL and testbench

- Second-generation image-processing controller for the LCD datapath.
- Loads a 2^XW x 2^YW image of DW-bit pixels from IROM into an internal buffer, then executes host commands on a 2x2 operation window.
- Streams the result to IRAM and raises done.
- Generalises pixel width and image geometry; adds edge-wrap mode, a reload command and an origin-reset command.

---
 rtl/lcd_ctrl_gen.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_ctrl_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_ctrl_gen : IROM image loader, 2x2 window command engine, IRAM streamer
// rev 1.0
// ---------------------------------------------------------------------------
module lcd_ctrl_gen #(
  parameter int DW   = 8,
  parameter int XW   = 3,
  parameter int YW   = 3,
  parameter int WRAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  input  logic [DW-1:0]    IROM_Q,
  output logic             IROM_rd,
  output logic [XW+YW-1:0] IROM_A,
  output logic             IRAM_valid,
  output logic [DW-1:0]    IRAM_D,
  output logic [XW+YW-1:0] IRAM_A,
  output logic             busy,
  output logic             done
);

  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [XW-1:0] c_X0   = XW'((1 << (XW - 1)) - 1);
  localparam logic [YW-1:0] c_Y0   = YW'((1 << (YW - 1)) - 1);
  localparam logic [XW-1:0] c_XMAX = XW'((1 << XW) - 2);
  localparam logic [YW-1:0] c_YMAX = YW'((1 << YW) - 2);
  localparam logic [AW-1:0] c_LAST = '1;

  logic [2:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic          r_busy;
  logic          r_done;
  logic          r_wvalid;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_buf [N];

  logic [XW-1:0] w_x1;
  logic [YW-1:0] w_y1;
  logic [AW-1:0] w_a0, w_a1, w_a2, w_a3, w_wa_nx;
  logic [DW-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [DW-1:0] w_mx01, w_mx23, w_max, w_mn01, w_mn23, w_min, w_avg;
  logic [DW+1:0] w_sum;
  logic [DW-1:0] w_n0, w_n1, w_n2, w_n3;
  logic          w_wr, w_acc_exec, w_acc_fin;

  // Neighbour column/row simply rolls over; with WRAP=0 the origin never
  // reaches the last column/row, so the rollover is never observed.
  assign w_x1    = r_ox + 1'b1;
  assign w_y1    = r_oy + 1'b1;
  assign w_a0    = {r_oy, r_ox};
  assign w_a1    = {r_oy, w_x1};
  assign w_a2    = {w_y1, r_ox};
  assign w_a3    = {w_y1, w_x1};
  assign w_wa_nx = r_wa + 1'b1;

  assign w_p0 = r_buf[w_a0];
  assign w_p1 = r_buf[w_a1];
  assign w_p2 = r_buf[w_a2];
  assign w_p3 = r_buf[w_a3];

  assign w_mx01 = (w_p0 > w_p1) ? w_p0 : w_p1;
  assign w_mx23 = (w_p2 > w_p3) ? w_p2 : w_p3;
  assign w_max  = (w_mx01 > w_mx23) ? w_mx01 : w_mx23;
  assign w_mn01 = (w_p0 < w_p1) ? w_p0 : w_p1;
  assign w_mn23 = (w_p2 < w_p3) ? w_p2 : w_p3;
  assign w_min  = (w_mn01 < w_mn23) ? w_mn01 : w_mn23;
  assign w_sum  = {2'b00, w_p0} + {2'b00, w_p1} + {2'b00, w_p2} + {2'b00, w_p3};
  assign w_avg  = w_sum[DW+1:2];

  assign w_acc_exec = cmd_valid && !r_busy && (r_state == S_EXEC);
  assign w_acc_fin  = cmd_valid && !r_busy && (r_state == S_FINISH);

  always_comb begin
    w_n0 = w_p0;
    w_n1 = w_p1;
    w_n2 = w_p2;
    w_n3 = w_p3;
    w_wr = 1'b0;
    if (w_acc_exec) begin
      w_wr = 1'b1;
      case (cmd)
        4'd5:    begin w_n0 = w_max; w_n1 = w_max; w_n2 = w_max; w_n3 = w_max; end
        4'd6:    begin w_n0 = w_min; w_n1 = w_min; w_n2 = w_min; w_n3 = w_min; end
        4'd7:    begin w_n0 = w_avg; w_n1 = w_avg; w_n2 = w_avg; w_n3 = w_avg; end
        4'd8:    begin w_n0 = w_p1;  w_n1 = w_p3;  w_n3 = w_p2;  w_n2 = w_p0;  end
        4'd9:    begin w_n1 = w_p0;  w_n3 = w_p1;  w_n2 = w_p3;  w_n0 = w_p2;  end
        4'd10:   begin w_n0 = w_p2;  w_n2 = w_p0;  w_n1 = w_p3;  w_n3 = w_p1;  end
        4'd11:   begin w_n0 = w_p1;  w_n1 = w_p0;  w_n2 = w_p3;  w_n3 = w_p2;  end
        default: w_wr = 1'b0;
      endcase
    end
  end

  // Image storage carries no reset; it is only written in LOAD or on a window command.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_buf[r_ptr] <= IROM_Q;
    end else if (w_wr) begin
      r_buf[w_a0] <= w_n0;
      r_buf[w_a1] <= w_n1;
      r_buf[w_a2] <= w_n2;
      r_buf[w_a3] <= w_n3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_ox     <= c_X0;
      r_oy     <= c_Y0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_wvalid <= 1'b0;
      r_wa     <= '0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_LOAD;
          r_ptr   <= '0;
        end
        S_LOAD: begin
          if (r_ptr == c_LAST) begin
            r_state <= S_EXEC;
            r_busy  <= 1'b0;
            r_ox    <= c_X0;
            r_oy    <= c_Y0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_EXEC: begin
          if (w_acc_exec) begin
            case (cmd)
              4'd0: begin
                r_state  <= S_WRITE;
                r_busy   <= 1'b1;
                r_wvalid <= 1'b1;
                r_wa     <= '0;
                r_wd     <= r_buf[0];
              end
              4'd1: if (WRAP != 0 || r_oy != '0)     r_oy <= r_oy - 1'b1;
              4'd2: if (WRAP != 0 || r_oy != c_YMAX) r_oy <= r_oy + 1'b1;
              4'd3: if (WRAP != 0 || r_ox != '0)     r_ox <= r_ox - 1'b1;
              4'd4: if (WRAP != 0 || r_ox != c_XMAX) r_ox <= r_ox + 1'b1;
              4'd12: begin
                r_state <= S_LOAD;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_ptr   <= '0;
              end
              4'd13: begin
                r_ox <= c_X0;
                r_oy <= c_Y0;
              end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          if (r_wa == c_LAST) begin
            r_wvalid <= 1'b0;
            r_state  <= S_FINISH;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_wa <= w_wa_nx;
            r_wd <= r_buf[w_wa_nx];
          end
        end
        S_FINISH: begin
          if (w_acc_fin && cmd == 4'd12) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ptr   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IROM_rd    = (r_state == S_LOAD);
  assign IROM_A     = r_ptr;
  assign IRAM_valid = r_wvalid;
  assign IRAM_A     = r_wa;
  assign IRAM_D     = r_wd;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_gen.sv
`default_nettype none
`timescale 1ns/1ps
// tb_lcd_ctrl_gen: directed commands on three parameterisations; expected IRAM
// beats are queued by the stimulus and checked by an independent monitor.
module tb_lcd_ctrl_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_s;
  logic [2:0] cv_s;
  logic [3:0] cmd_s [3];
  wire  [2:0] busy_s, done_s, val_s, rd_s;

  wire [5:0] a_roma, a_rama, b_roma, b_rama;
  wire [7:0] a_romq, a_ramd, b_romq, b_ramd;
  wire [4:0] c_roma, c_rama;
  wire [9:0] c_romq, c_ramd;

  assign a_romq = {2'b00, a_roma};
  assign b_romq = {2'b00, b_roma};
  assign c_romq = 10'd1023 - {5'd0, c_roma};

  lcd_ctrl_gen #(.DW(8), .XW(3), .YW(3), .WRAP(0)) u_a (
    .clk(clk), .reset(rst_s[0]), .cmd(cmd_s[0]), .cmd_valid(cv_s[0]),
    .IROM_Q(a_romq), .IROM_rd(rd_s[0]), .IROM_A(a_roma),
    .IRAM_valid(val_s[0]), .IRAM_D(a_ramd), .IRAM_A(a_rama),
    .busy(busy_s[0]), .done(done_s[0]));

  lcd_ctrl_gen #(.DW(8), .XW(3), .YW(3), .WRAP(1)) u_b (
    .clk(clk), .reset(rst_s[1]), .cmd(cmd_s[1]), .cmd_valid(cv_s[1]),
    .IROM_Q(b_romq), .IROM_rd(rd_s[1]), .IROM_A(b_roma),
    .IRAM_valid(val_s[1]), .IRAM_D(b_ramd), .IRAM_A(b_rama),
    .busy(busy_s[1]), .done(done_s[1]));

  lcd_ctrl_gen #(.DW(10), .XW(2), .YW(3), .WRAP(0)) u_c (
    .clk(clk), .reset(rst_s[2]), .cmd(cmd_s[2]), .cmd_valid(cv_s[2]),
    .IROM_Q(c_romq), .IROM_rd(rd_s[2]), .IROM_A(c_roma),
    .IRAM_valid(val_s[2]), .IRAM_D(c_ramd), .IRAM_A(c_rama),
    .busy(busy_s[2]), .done(done_s[2]));

  typedef struct {
    int a;
    int d;
  } beat_t;

  beat_t exp_q[$];
  int    n_total = 0;
  int    n_bad   = 0;
  int    lcnt[3];
  int    llen[3];
  int    img[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic mon_beat(input int k, input logic v, input int a, input int d);
    beat_t e;
    if (v) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL beat_unexpected inst%0d: got addr %0d data %0d, required no beat", k, a, d);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("beat_addr inst%0d", k), a, e.a);
        check($sformatf("beat_data inst%0d addr %0d", k, e.a), d, e.d);
      end
    end
  endtask

  task automatic mon_load(input int k, input logic rd, input int a);
    if (rd) begin
      check($sformatf("load_addr inst%0d", k), a, lcnt[k]);
      lcnt[k]++;
    end else if (lcnt[k] != 0) begin
      llen[k] = lcnt[k];
      lcnt[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon_beat(0, val_s[0], int'(a_rama), int'(a_ramd));
    mon_beat(1, val_s[1], int'(b_rama), int'(b_ramd));
    mon_beat(2, val_s[2], int'(c_rama), int'(c_ramd));
    mon_load(0, rd_s[0], int'(a_roma));
    mon_load(1, rd_s[1], int'(b_roma));
    mon_load(2, rd_s[2], int'(c_roma));
  end

  task automatic push_img(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.a = i;
      b.d = img[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic issue(input int k, input logic [3:0] c);
    cmd_s[k] = c;
    cv_s[k]  = 1'b1;
    @(negedge clk);
    cv_s[k]  = 1'b0;
  endtask

  task automatic wait_exec(input int k, input int len);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_s[k] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    cv_s[k] = 1'b0;
    @(negedge clk);
    check($sformatf("busy_fall inst%0d", k), 32'(ok), 32'd1);
    check($sformatf("load_len inst%0d", k), llen[k], len);
    check($sformatf("exec_done_low inst%0d", k), 32'(done_s[k]), 32'd0);
  endtask

  task automatic wait_done(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_s[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("done_rise inst%0d", k), 32'(ok), 32'd1);
    check($sformatf("finish_busy inst%0d", k), 32'(busy_s[k]), 32'd0);
    check($sformatf("beats_left inst%0d", k), exp_q.size(), 32'd0);
  endtask

  task automatic ident(input int n, input bit inv);
    for (int i = 0; i < n; i++) img[i] = inv ? 1023 - i : i;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_s = 3'b111;
    cv_s  = 3'b000;
    for (int i = 0; i < 3; i++) cmd_s[i] = 4'd0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy_s[0]), 32'd1);
    check("rst_done", 32'(done_s[0]), 32'd0);
    check("rst_iram_valid", 32'(val_s[0]), 32'd0);
    check("rst_iram_a", 32'(a_rama), 32'd0);
    check("rst_iram_d", 32'(a_ramd), 32'd0);
    check("rst_irom_rd", 32'(rd_s[0]), 32'd0);

    // Instance A: cmd 0 held during the first load must not start a write.
    cmd_s[0] = 4'd0;
    cv_s[0]  = 1'b1;
    rst_s[0] = 1'b0;
    wait_exec(0, 64);

    ident(64, 0);
    push_img(64);
    issue(0, 4'd0);
    wait_done(0);

    issue(0, 4'd5);
    issue(0, 4'd0);
    repeat (3) @(negedge clk);
    check("finish_hold_done", 32'(done_s[0]), 32'd1);

    issue(0, 4'd12);
    check("reload_busy", 32'(busy_s[0]), 32'd1);
    check("reload_done", 32'(done_s[0]), 32'd0);
    wait_exec(0, 64);

    ident(64, 0);
    img[27] = 31; img[28] = 31; img[35] = 31; img[36] = 31;
    push_img(64);
    issue(0, 4'd7);
    issue(0, 4'd0);
    wait_done(0);

    issue(0, 4'd12);
    wait_exec(0, 64);
    repeat (6) issue(0, 4'd4);
    issue(0, 4'd9);
    ident(64, 0);
    img[30] = 38; img[31] = 30; img[38] = 39; img[39] = 31;
    push_img(64);
    issue(0, 4'd0);
    wait_done(0);

    issue(0, 4'd12);
    wait_exec(0, 64);
    issue(0, 4'd1);
    issue(0, 4'd14);
    issue(0, 4'd13);
    issue(0, 4'd11);
    ident(64, 0);
    img[27] = 28; img[28] = 27; img[35] = 36; img[36] = 35;
    push_img(64);
    issue(0, 4'd0);
    wait_done(0);

    // Instance B: wrap mode.
    rst_s[1] = 1'b0;
    wait_exec(1, 64);
    repeat (5) issue(1, 4'd4);
    issue(1, 4'd3);
    issue(1, 4'd5);
    ident(64, 0);
    img[31] = 39; img[24] = 39; img[39] = 39; img[32] = 39;
    push_img(64);
    issue(1, 4'd0);
    wait_done(1);

    // Instance C: 4x8 image of 10-bit pixels, ROM[i] = 1023-i.
    rst_s[2] = 1'b0;
    wait_exec(2, 32);
    issue(2, 4'd6);
    ident(32, 1);
    img[13] = 1005; img[14] = 1005; img[17] = 1005; img[18] = 1005;
    push_img(32);
    issue(2, 4'd0);
    wait_done(2);

    issue(2, 4'd12);
    wait_exec(2, 32);
    ident(32, 1);
    push_img(11);
    issue(2, 4'd0);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (val_s[2] === 1'b1 && c_rama == 5'd10) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("beat10_seen", 32'(hit), 32'd1);
    #2 rst_s[2] = 1'b1;
    #1;
    check("midrst_valid", 32'(val_s[2]), 32'd0);
    check("midrst_busy", 32'(busy_s[2]), 32'd1);
    check("midrst_done", 32'(done_s[2]), 32'd0);
    check("midrst_iram_a", 32'(c_rama), 32'd0);
    check("midrst_beats_left", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_s[2] = 1'b0;
    wait_exec(2, 32);
    ident(32, 1);
    push_img(32);
    issue(2, 4'd0);
    wait_done(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
